grover_engine: RTL and testbench



---
 rtl/grover_engine.sv | 150 +++++++++++++++
 tb/tb_grover_engine.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/grover_engine.sv
// Grover-search amplitude engine: multi-target phase oracle followed by
// inversion-about-mean, with the mean accumulated one sample per cycle.
//
// state   | meaning
// IDLE    | waiting for start
// INIT    | load equal superposition, clear iteration count
// ORACLE  | negate marked amplitudes, clear accumulator and pointer
// SUM     | accumulate one amplitude per cycle for N cycles
// DIFFUSE | reflect every amplitude about the mean, count the iteration
// DONE    | amplitudes frozen, result available
module grover_engine #(
    parameter int NUM_BIT  = 3,
    parameter int FP_BIT   = 8,
    parameter int INIT_AMP = 22,
    parameter int DEF_ITE  = 2,
    parameter int ITE_W    = 8
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               start,
    input  logic                               abort,
    input  logic [(1<<NUM_BIT)-1:0]            target_mask,
    input  logic [ITE_W-1:0]                   ite_cfg,
    output logic                               busy,
    output logic                               done,
    output logic [ITE_W-1:0]                   ite_count,
    input  logic [NUM_BIT-1:0]                 rd_addr,
    output logic [FP_BIT-1:0]                  rd_data,
    output logic [(1<<NUM_BIT)*FP_BIT-1:0]     amp_bus
);
    localparam int N      = 1 << NUM_BIT;
    localparam int ACC_W  = FP_BIT + NUM_BIT;
    localparam int WIDE_W = FP_BIT + 2;
    localparam logic signed [FP_BIT-1:0] AMP_MAX = {1'b0, {(FP_BIT-1){1'b1}}};
    localparam logic signed [FP_BIT-1:0] AMP_MIN = {1'b1, {(FP_BIT-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE, S_INIT, S_ORACLE, S_SUM, S_DIFFUSE, S_DONE
    } state_t;

    state_t state, state_nxt;

    logic signed [FP_BIT-1:0] amp [N];
    logic signed [ACC_W-1:0]  acc;
    logic signed [FP_BIT-1:0] mean;
    logic [NUM_BIT-1:0]       ptr;
    logic [N-1:0]             mask_q;
    logic [ITE_W-1:0]         k_q;
    logic [ITE_W-1:0]         k_eff;
    logic                     start_ok;
    logic                     last_ite;

    function automatic logic signed [FP_BIT-1:0] neg_sat(input logic signed [FP_BIT-1:0] a);
        if (a == AMP_MIN) return AMP_MAX;
        return -a;
    endfunction

    // 2*mean - a needs two extra bits before clamping back to FP_BIT
    function automatic logic signed [FP_BIT-1:0] reflect_sat(
        input logic signed [FP_BIT-1:0] m,
        input logic signed [FP_BIT-1:0] a
    );
        logic signed [WIDE_W-1:0] w;
        w = (WIDE_W'(m) <<< 1) - WIDE_W'(a);
        if (w > WIDE_W'(AMP_MAX)) return AMP_MAX;
        if (w < WIDE_W'(AMP_MIN)) return AMP_MIN;
        return FP_BIT'(w);
    endfunction

    assign k_eff    = (ite_cfg == '0) ? ITE_W'(DEF_ITE) : ite_cfg;
    assign start_ok = start && !abort && (state == S_IDLE || state == S_DONE);
    assign last_ite = (ite_count + ITE_W'(1)) == k_q;
    assign mean     = FP_BIT'(acc >>> NUM_BIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (abort) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE, S_DONE: if (start) state_nxt = S_INIT;
                S_INIT:         state_nxt = (k_q == '0) ? S_DONE : S_ORACLE;
                S_ORACLE:       state_nxt = S_SUM;
                S_SUM:          if (ptr == NUM_BIT'(N-1)) state_nxt = S_DIFFUSE;
                S_DIFFUSE:      state_nxt = last_ite ? S_DONE : S_ORACLE;
                default:        state_nxt = S_IDLE;
            endcase
        end
    end

    always_comb begin
        busy    = (state == S_INIT) || (state == S_ORACLE) ||
                  (state == S_SUM)  || (state == S_DIFFUSE);
        done    = (state == S_DONE);
        rd_data = amp[rd_addr];
        amp_bus = '0;
        for (int i = 0; i < N; i++) begin
            amp_bus[i*FP_BIT +: FP_BIT] = amp[i];
        end
    end

    // abort suppresses the pending step so the bank keeps its last values
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) amp[i] <= '0;
            acc       <= '0;
            ptr       <= '0;
            ite_count <= '0;
            mask_q    <= '0;
            k_q       <= '0;
        end else begin
            if (start_ok) begin
                mask_q <= target_mask;
                k_q    <= k_eff;
            end
            if (!abort) begin
                case (state)
                    S_INIT: begin
                        for (int i = 0; i < N; i++) amp[i] <= FP_BIT'(INIT_AMP);
                        ite_count <= '0;
                    end
                    S_ORACLE: begin
                        for (int i = 0; i < N; i++) begin
                            if (mask_q[i]) amp[i] <= neg_sat(amp[i]);
                        end
                        acc <= '0;
                        ptr <= '0;
                    end
                    S_SUM: begin
                        acc <= acc + ACC_W'(amp[ptr]);
                        ptr <= ptr + NUM_BIT'(1);
                    end
                    S_DIFFUSE: begin
                        for (int i = 0; i < N; i++) amp[i] <= reflect_sat(mean, amp[i]);
                        ite_count <= ite_count + ITE_W'(1);
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_grover_engine.sv
// Self-checking bench for grover_engine: an integer model of the Grover
// iteration predicts final amplitudes and the busy/done timeline.
module tb_grover_engine;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0, start_k0 = 1'b0, start_sat = 1'b0;
    logic        abort = 1'b0;
    logic [7:0]  target_mask = '0;
    logic [7:0]  ite_cfg = '0;
    logic [2:0]  rd_addr = '0;

    logic        busy, done, busy_k0, done_k0, busy_sat, done_sat;
    logic [7:0]  ite_count, ite_k0, ite_sat;
    logic [7:0]  rd_data, rd_k0, rd_sat;
    logic [63:0] amp_bus, amp_k0, amp_sat;

    grover_engine u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .target_mask(target_mask), .ite_cfg(ite_cfg), .busy(busy), .done(done),
        .ite_count(ite_count), .rd_addr(rd_addr), .rd_data(rd_data), .amp_bus(amp_bus)
    );

    grover_engine #(.DEF_ITE(0)) u_k0 (
        .clk(clk), .rst_n(rst_n), .start(start_k0), .abort(abort),
        .target_mask(target_mask), .ite_cfg(ite_cfg), .busy(busy_k0), .done(done_k0),
        .ite_count(ite_k0), .rd_addr(rd_addr), .rd_data(rd_k0), .amp_bus(amp_k0)
    );

    grover_engine #(.INIT_AMP(-128)) u_sat (
        .clk(clk), .rst_n(rst_n), .start(start_sat), .abort(abort),
        .target_mask(target_mask), .ite_cfg(ite_cfg), .busy(busy_sat), .done(done_sat),
        .ite_count(ite_sat), .rd_addr(rd_addr), .rd_data(rd_sat), .amp_bus(amp_sat)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int errors  = 0;
    int exp_amp [8];
    int exp_ite;
    int exp_t;
    int e;
    bit track = 0;
    bit const_chk = 0;

    task automatic chk(input string name, input int act, input int req);
        vectors++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic int amp_of(input logic [63:0] bus, input int i);
        logic signed [7:0] v;
        v = bus[i*8 +: 8];
        return int'(v);
    endfunction

    function automatic int clamp(input int x);
        if (x > 127) return 127;
        if (x < -128) return -128;
        return x;
    endfunction

    function automatic int floor_div8(input int s);
        if (s >= 0) return s / 8;
        return -((-s + 7) / 8);
    endfunction

    // Grover iteration on plain integers: oracle, mean, reflection
    function automatic void model_run(input int init, input logic [7:0] m, input int k);
        int sum;
        int mean;
        for (int i = 0; i < 8; i++) exp_amp[i] = init;
        for (int it = 0; it < k; it++) begin
            for (int i = 0; i < 8; i++) if (m[i]) exp_amp[i] = clamp(-exp_amp[i]);
            sum = 0;
            for (int i = 0; i < 8; i++) sum += exp_amp[i];
            mean = floor_div8(sum);
            for (int i = 0; i < 8; i++) exp_amp[i] = clamp(2 * mean - exp_amp[i]);
        end
        exp_ite = k;
    endfunction

    always @(negedge clk) begin
        if (track) begin
            chk("busy", int'(busy), int'(e < exp_t));
            chk("done", int'(done), int'(e >= exp_t));
            if (const_chk && e >= 1) begin
                for (int i = 0; i < 8; i++) chk("uniform_amp", amp_of(amp_bus, i), 22);
            end
            if (e == exp_t) begin
                for (int i = 0; i < 8; i++) chk("final_amp", amp_of(amp_bus, i), exp_amp[i]);
                chk("ite_count", int'(ite_count), exp_ite);
            end
            e++;
        end
    end

    task automatic run(input logic [7:0] m, input logic [7:0] cfg, input bit disturb);
        int k;
        k = (cfg == 8'd0) ? 2 : int'(cfg);
        model_run(22, m, k);
        exp_t = 1 + k * 10;
        @(negedge clk);
        target_mask = m;
        ite_cfg = cfg;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        e = 0;
        track = 1;
        for (int c = 1; c <= exp_t + 1; c++) begin
            @(posedge clk); #1;
            if (disturb) begin
                start = (c == 4);
                target_mask = ~m;
                ite_cfg = 8'd7;
            end
        end
        start = 1'b0;
        track = 0;
    endtask

    task automatic run_sat(input logic [7:0] m);
        model_run(-128, m, 1);
        @(negedge clk);
        target_mask = m;
        ite_cfg = 8'd1;
        start_sat = 1'b1;
        @(negedge clk);
        start_sat = 1'b0;
        repeat (11) @(negedge clk);
        chk("sat_done", int'(done_sat), 1);
        for (int i = 0; i < 8; i++) chk("sat_amp", amp_of(amp_sat, i), exp_amp[i]);
    endtask

    initial begin
        #12;
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_ite", int'(ite_count), 0);
        chk("rst_bus_zero", int'(amp_bus == 64'd0), 1);
        @(negedge clk);
        rst_n = 1'b1;

        run(8'h20, 8'd1, 0);
        chk("k1_a5", amp_of(amp_bus, 5), 54);
        chk("k1_a0", amp_of(amp_bus, 0), 10);

        run(8'h20, 8'd0, 0);
        rd_addr = 3'd5; #1;
        chk("k2_rd5", int'($signed(rd_data)), 58);
        rd_addr = 3'd2; #1;
        chk("k2_rd2", int'($signed(rd_data)), -6);

        const_chk = 1;
        run(8'h00, 8'd3, 0);
        const_chk = 0;

        run(8'hFF, 8'd1, 0);
        chk("ff_a3", amp_of(amp_bus, 3), -22);

        run(8'h81, 8'd1, 0);
        chk("two_a7", amp_of(amp_bus, 7), 44);
        chk("two_a3", amp_of(amp_bus, 3), 0);

        run(8'h20, 8'd0, 1);
        chk("dist_a5", amp_of(amp_bus, 5), 58);
        run(8'h20, 8'd0, 0);

        // abort while in DIFFUSE: diffusion step is dropped
        @(negedge clk);
        target_mask = 8'h20;
        ite_cfg = 8'd1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("pre_abort_busy", int'(busy), 1);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        chk("abort_busy", int'(busy), 0);
        chk("abort_done", int'(done), 0);
        chk("abort_a5", amp_of(amp_bus, 5), -22);
        chk("abort_a0", amp_of(amp_bus, 0), 22);
        chk("abort_ite", int'(ite_count), 0);
        @(posedge clk); #1;
        chk("abort_stay_idle", int'(busy | done), 0);

        // async reset in the middle of SUM
        @(negedge clk);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_bus", int'(amp_bus == 64'd0), 1);
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_done", int'(done), 0);
        chk("mid_rst_ite", int'(ite_count), 0);
        @(negedge clk);
        rst_n = 1'b1;
        run(8'h81, 8'd1, 0);

        // DEF_ITE = 0: INIT then straight to DONE
        @(negedge clk);
        ite_cfg = 8'd0;
        start_k0 = 1'b1;
        @(negedge clk);
        start_k0 = 1'b0;
        chk("k0_busy", int'(busy_k0), 1);
        chk("k0_done_early", int'(done_k0), 0);
        @(negedge clk);
        chk("k0_done", int'(done_k0), 1);
        chk("k0_ite", int'(ite_k0), 0);
        for (int i = 0; i < 8; i++) chk("k0_amp", amp_of(amp_k0, i), 22);

        run_sat(8'h01);
        chk("sat_lo_a0", amp_of(amp_sat, 0), -128);
        chk("sat_lo_a1", amp_of(amp_sat, 1), -66);
        run_sat(8'hFE);
        chk("sat_hi_a0", amp_of(amp_sat, 0), 127);
        chk("sat_hi_a1", amp_of(amp_sat, 1), 63);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
